// File: rtl/pico_rtc_pkg.sv
// RTC register map, port-to-address table and write-sequencer state encoding
// shared by the PicoBlaze write queue; pure declarations, no timing or flow control.
package pico_rtc_pkg;

  localparam logic [7:0] ADDR_SEG    = 8'h21;
  localparam logic [7:0] ADDR_MIN    = 8'h22;
  localparam logic [7:0] ADDR_HORA   = 8'h23;
  localparam logic [7:0] ADDR_DIA    = 8'h24;
  localparam logic [7:0] ADDR_MES    = 8'h25;
  localparam logic [7:0] ADDR_ANO    = 8'h26;
  localparam logic [7:0] ADDR_T_HORA = 8'h41;
  localparam logic [7:0] ADDR_T_MIN  = 8'h42;
  localparam logic [7:0] ADDR_T_SEG  = 8'h43;

  // Element 0 is the rightmost byte; channels 9..15 are unpopulated.
  localparam logic [15:0][7:0] ADDR_TABLE = {
    {7{8'h00}},
    ADDR_T_SEG, ADDR_T_MIN, ADDR_T_HORA,
    ADDR_SEG, ADDR_MIN, ADDR_HORA,
    ADDR_ANO, ADDR_MES, ADDR_DIA
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } wr_state_t;

  function automatic logic [7:0] rtc_addr(input logic [3:0] ch);
    return ADDR_TABLE[ch];
  endfunction

endpackage

// File: rtl/pico_wr_fifo.sv
// Synchronous FIFO of DEPTH entries, head shown combinationally; a push while full is
// accepted only when a pop happens at the same edge, otherwise it is refused.
module pico_wr_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pico_wr_queue.sv
// Decodes PicoBlaze port writes into {RTC address, data} entries, queues them and offers
// the head to the RTC sequencer; push-to-request is 2 edges; writes to a full queue are dropped (sticky ovf).
module pico_wr_queue
  import pico_rtc_pkg::*;
#(
  parameter logic [7:0] PORT_BASE = 8'h13,
  parameter int         NUM_CH    = 9,
  parameter int         DATA_W    = 8,
  parameter int         ADDR_W    = 8,
  parameter int         DEPTH     = 4,
  parameter logic [7:0] CLR_PORT  = 8'h1F
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             port_id,
  input  logic                   write_strobe,
  input  logic [DATA_W-1:0]      out_port,
  input  logic                   wr_done,
  output logic [ADDR_W-1:0]      ADD,
  output logic [DATA_W-1:0]      out_data_wr,
  output logic                   en_progra,
  output logic                   Sw,
  output logic                   full,
  output logic                   ovf,
  output logic [$clog2(DEPTH):0] pending
);

  localparam int         ENT_W   = ADDR_W + DATA_W;
  localparam logic [8:0] NUM_CH9 = 9'(NUM_CH);

  logic [7:0]       ch_off;
  logic             in_win;
  logic             push;
  logic             pop;
  logic             clr;
  logic             ovf_set;
  logic             fifo_empty;
  logic             load_head;
  logic [ENT_W-1:0] wr_ent;
  logic [ENT_W-1:0] head;
  wr_state_t        state;
  wr_state_t        state_nxt;

  // Reject ports below the base first so the 8-bit offset never wraps into the window.
  assign ch_off  = port_id - PORT_BASE;
  assign in_win  = (port_id >= PORT_BASE) && ({1'b0, ch_off} < NUM_CH9);
  assign push    = write_strobe && in_win;
  assign clr     = write_strobe && (port_id == CLR_PORT);
  assign pop     = (state == ST_REQ) && wr_done;
  assign ovf_set = push && full && !pop;
  assign wr_ent  = {ADDR_W'(rtc_addr(ch_off[3:0])), out_port};

  pico_wr_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wr_ent),
    .rdata (head),
    .full  (full),
    .empty (fifo_empty),
    .count (pending)
  );

  always_comb begin
    state_nxt = state;
    en_progra = 1'b0;
    Sw        = 1'b0;
    load_head = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_nxt = ST_REQ;
          load_head = 1'b1;
        end
      end
      ST_REQ: begin
        en_progra = 1'b1;
        Sw        = 1'b1;
        if (wr_done) begin
          state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (!fifo_empty) begin
          state_nxt = ST_REQ;
          load_head = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Head is captured on entry to REQ so it stays stable for the whole request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ADD         <= '0;
      out_data_wr <= '0;
    end else if (load_head) begin
      {ADD, out_data_wr} <= head;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (ovf_set) begin
      ovf <= 1'b1;
    end else if (clr) begin
      ovf <= 1'b0;
    end
  end

endmodule
